plic_irq_sink: RTL and testbench

- AXI4-Lite client that receives the interrupt-level writes issued by the PLIC-side IRQ-to-AXIL master.
- Holds one interrupt-pending bit per target in a register and drives it as the level `irq_o` into the BlackParrot core / CFG side.
- Supports readback of that register, and answers any other address with SLVERR.
- Sits at `base_addr_p` (default S-mode PLIC address `'h30_a000`) on the client side of the AXI-Lite crossbar.

---
 rtl/plic_irq_sink.sv | 180 ++++++++++++++++++
 tb/tb_plic_irq_sink.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_irq_sink.sv
// plic_irq_sink: AXI4-Lite client holding per-target interrupt levels.
// Optional edge counter at base+4 enabled by PLIC_IRQ_SINK_EDGE_COUNT_EN.
module plic_irq_sink #(
    parameter int unsigned axil_data_width_p = 32,
    parameter int unsigned axil_addr_width_p = 32,
    parameter int unsigned num_targets_p     = 2,
    parameter logic [axil_addr_width_p-1:0] base_addr_p = 'h30_a000
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic [2:0]                     s_axil_awprot_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,
    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,
    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic [2:0]                     s_axil_arprot_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,
    output logic [num_targets_p-1:0]       irq_o
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e                         w_state_q;
    r_state_e                         r_state_q;
    logic [num_targets_p-1:0]         irq_q, irq_d;
    logic [1:0]                       bresp_q, wr_resp_d;
    logic                             bvalid_q;
    logic [axil_data_width_p-1:0]     rdata_q, rd_data_d;
    logic [1:0]                       rresp_q, rd_resp_d;
    logic                             rvalid_q;
    logic                             wr_accept;
    logic                             rd_accept;
    logic                             wr_hit_irq;
    logic [num_targets_p-1:0]         wr_bits;

`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
    localparam logic [axil_addr_width_p-1:0] CntAddr =
        base_addr_p + axil_addr_width_p'(4);
    logic [31:0] cnt_q, cnt_d;
    logic        wr_hit_cnt;
    assign wr_hit_cnt = (s_axil_awaddr_i == CntAddr);
`endif

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot_i, s_axil_arprot_i,
                             s_axil_wdata_i[axil_data_width_p-1:num_targets_p],
                             s_axil_wstrb_i[axil_data_width_p/8-1:1]};

    assign wr_accept  = (w_state_q == W_IDLE) & s_axil_awvalid_i & s_axil_wvalid_i;
    assign rd_accept  = (r_state_q == R_IDLE) & s_axil_arvalid_i;
    assign wr_hit_irq = (s_axil_awaddr_i == base_addr_p);
    assign wr_bits    = s_axil_wdata_i[num_targets_p-1:0];

    assign s_axil_awready_o = wr_accept;
    assign s_axil_wready_o  = wr_accept;
    assign s_axil_arready_o = rd_accept;
    assign s_axil_bresp_o   = bresp_q;
    assign s_axil_bvalid_o  = bvalid_q;
    assign s_axil_rdata_o   = rdata_q;
    assign s_axil_rresp_o   = rresp_q;
    assign s_axil_rvalid_o  = rvalid_q;
    assign irq_o            = irq_q;

    // Write decode: next irq level, counter and response for an accepted write
    always_comb begin
        irq_d     = irq_q;
        wr_resp_d = RespSlverr;
`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
        cnt_d     = cnt_q;
`endif
        if (wr_hit_irq) begin
            wr_resp_d = RespOkay;
            if (wr_accept && s_axil_wstrb_i[0]) begin
                irq_d = wr_bits;
`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
                if (|(wr_bits & ~irq_q)) cnt_d = cnt_q + 32'd1;
`endif
            end
        end
`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
        else if (wr_hit_cnt) begin
            wr_resp_d = RespOkay;
            if (wr_accept && s_axil_wstrb_i[0]) cnt_d = '0;
        end
`endif
    end

    // Read decode: data and response captured when a read is accepted
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RespSlverr;
        if (s_axil_araddr_i == base_addr_p) begin
            rd_data_d[num_targets_p-1:0] = irq_q;
            rd_resp_d = RespOkay;
        end
`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
        else if (s_axil_araddr_i == CntAddr) begin
            rd_data_d[31:0] = cnt_q;
            rd_resp_d = RespOkay;
        end
`endif
    end

    // Write FSM with the interrupt register and B channel outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            irq_q     <= '0;
`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
            cnt_q     <= '0;
`endif
        end else begin
            irq_q <= irq_d;
`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
            cnt_q <= cnt_d;
`endif
            unique case (w_state_q)
                W_IDLE: begin
                    if (wr_accept) begin
                        bresp_q   <= wr_resp_d;
                        bvalid_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axil_bready_i) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Read FSM with R channel outputs held stable until the handshake
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (rd_accept) begin
                        rdata_q   <= rd_data_d;
                        rresp_q   <= rd_resp_d;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axil_rready_i) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plic_irq_sink.sv
// tb_plic_irq_sink: directed and randomized checks of plic_irq_sink.
// Counter checks are compiled in with PLIC_IRQ_SINK_EDGE_COUNT_EN.
module tb_plic_irq_sink;

    localparam logic [31:0] BASE = 32'h0030_a000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [1:0]  irq;

    int passed = 0;
    int total  = 0;

    logic [1:0]  irq_m;
    logic [31:0] cnt_m;

    always #5 clk = ~clk;

    plic_irq_sink dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .s_axil_awaddr_i  (awaddr),
        .s_axil_awprot_i  (awprot),
        .s_axil_awvalid_i (awvalid),
        .s_axil_awready_o (awready),
        .s_axil_wdata_i   (wdata),
        .s_axil_wstrb_i   (wstrb),
        .s_axil_wvalid_i  (wvalid),
        .s_axil_wready_o  (wready),
        .s_axil_bresp_o   (bresp),
        .s_axil_bvalid_o  (bvalid),
        .s_axil_bready_i  (bready),
        .s_axil_araddr_i  (araddr),
        .s_axil_arprot_i  (arprot),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready),
        .s_axil_rdata_o   (rdata),
        .s_axil_rresp_o   (rresp),
        .s_axil_rvalid_o  (rvalid),
        .s_axil_rready_i  (rready),
        .irq_o            (irq)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: register semantics from the address map
    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [1:0] resp);
        resp = 2'b10;
        if (a == BASE) begin
            resp = 2'b00;
            if (s[0]) begin
                if ((d[1:0] & ~irq_m) != 2'b00) cnt_m = cnt_m + 1;
                irq_m = d[1:0];
            end
        end
`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
        else if (a == BASE + 4) begin
            resp = 2'b00;
            if (s[0]) cnt_m = 0;
        end
`endif
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d,
                              output logic [1:0] resp);
        d = 0;
        resp = 2'b10;
        if (a == BASE) begin
            d = {30'd0, irq_m};
            resp = 2'b00;
        end
`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
        else if (a == BASE + 4) begin
            d = cnt_m;
            resp = 2'b00;
        end
`endif
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        logic [1:0] exp_resp;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("wr_accept", {awready, wready}, 2'b11);
        check("irq_before_edge", irq, irq_m);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(a, d, s, exp_resp);
        check("irq_after_wr", irq, irq_m);
        check("bvalid", bvalid, 1'b1);
        check("bresp", bresp, exp_resp);
        @(posedge clk); #1;
        check("bvalid_drop", bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        int n;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        model_read(a, exp_d, exp_r);
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        rready = (hold == 0);
        #1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("rd_accept", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid", rvalid, 1'b1);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("rvalid_hold", rvalid, 1'b1);
            check("rdata_hold", rdata, exp_d);
            check("rresp_hold", rresp, exp_r);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        check("rvalid_drop", rvalid, 1'b0);
    endtask

    initial begin
        int nb;
        int n;
        logic [31:0] a;
        reset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        irq_m = '0; cnt_m = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_irq", irq, 2'b00);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'd0);

        do_write(BASE, 32'h3, 4'hF);
        check("irq_11", irq, 2'b11);
        do_read(BASE, 3);
        do_write(BASE + 8, 32'h1, 4'hF);
        check("irq_kept", irq, 2'b11);
        do_read(BASE + 8, 0);
        do_write(BASE, 32'h0, 4'hE);
        check("irq_nostrb", irq, 2'b11);

        // AW presented alone; W joins four cycles later
        @(negedge clk);
        awaddr = BASE; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("aw_only_ready", {awready, wready}, 2'b00);
            @(negedge clk);
        end
        wvalid = 1'b1;
        #1;
        check("aw_w_ready", {awready, wready}, 2'b11);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        irq_m = 2'b01;
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            if (bvalid) nb++;
            @(posedge clk); #1;
        end
        check("one_b_resp", nb, 1);
        check("irq_01", irq, irq_m);

        // Concurrent write of 0 and read of the register holding 2
        do_write(BASE, 32'h2, 4'hF);
        @(negedge clk);
        awaddr = BASE; wdata = 32'h0; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = BASE; arvalid = 1'b1;
        #1;
        check("conc_ready", {awready, arready}, 2'b11);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("conc_rdata", rdata, 32'h2);
        check("conc_rvalid", rvalid, 1'b1);
        check("conc_irq", irq, 2'b00);
        check("conc_bresp", {bvalid, bresp}, 3'b100);
        irq_m = 2'b00;
        @(posedge clk); #1;

        // Reset with a B response still pending
        do_write(BASE, 32'h3, 4'hF);
        @(negedge clk);
        bready = 1'b0;
        awaddr = BASE; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("pend_bvalid", bvalid, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bready = 1'b1;
        irq_m = 2'b00; cnt_m = 0;
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_irq", irq, 2'b00);

`ifdef PLIC_IRQ_SINK_EDGE_COUNT_EN
        do_write(BASE, 32'h1, 4'hF);
        do_write(BASE, 32'h1, 4'hF);
        do_write(BASE, 32'h3, 4'hF);
        do_write(BASE, 32'h0, 4'hF);
        do_write(BASE, 32'h2, 4'hF);
        check("cnt_model", cnt_m, 32'd3);
        do_read(BASE + 4, 1);
        do_write(BASE + 4, 32'h0, 4'h1);
        do_read(BASE + 4, 0);
`else
        do_read(BASE + 4, 0);
        do_write(BASE + 4, 32'h0, 4'hF);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 3);
            case (n)
                0: a = BASE;
                1: a = BASE + 4;
                2: a = BASE + 8;
                default: a = $urandom & 32'hFFFF_FFFC;
            endcase
            do_write(a, $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(0, 2);
                a = (n == 0) ? BASE : ((n == 1) ? BASE + 4 : ($urandom & 32'hFFFF_FFFC));
                do_read(a, $urandom_range(0, 2));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
